// File: rtl/matrix_led_rx.sv
`timescale 1ns/1ps
// matrix_led_rx: oversampled MAX7219-style CLK/DIN/CS receiver that decodes 16-bit frames into a display register file.
// Latency: frame_valid/frame_err fire SYNC_STAGES+2 clk after raw CS rises. Backpressure: none, every frame is accepted or rejected.
module matrix_led_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        matrix_CLK,
   input  logic        matrix_DIN,
   input  logic        matrix_CS,
   output logic [63:0] rows,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        shutdown_n,
   output logic        display_test,
   output logic        frame_valid,
   output logic [3:0]  frame_addr,
   output logic [7:0]  frame_data,
   output logic        frame_err
);

   typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT, LATCH} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_din_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_clk_d;
   logic                   r_cs_d;
   logic [11:0]            r_sr;
   logic [4:0]             r_count;
   logic                   w_clk_s;
   logic                   w_din_s;
   logic                   w_cs_s;
   logic                   w_clk_rise;
   logic                   w_cs_rise;
   logic                   w_cs_fall;
   logic                   w_latch;
   logic                   w_accept;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_clk_sync <= '0;
         r_din_sync <= '0;
         r_cs_sync  <= '0;
         r_clk_d    <= 1'b0;
         r_cs_d     <= 1'b0;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], matrix_CLK};
         r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], matrix_DIN};
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], matrix_CS};
         r_clk_d    <= w_clk_s;
         r_cs_d     <= w_cs_s;
      end
   end

   assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
   assign w_din_s    = r_din_sync[SYNC_STAGES-1];
   assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
   assign w_clk_rise = w_clk_s & ~r_clk_d;
   assign w_cs_rise  = w_cs_s & ~r_cs_d;
   assign w_cs_fall  = ~w_cs_s & r_cs_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= WAIT_HI;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // WAIT_HI guards against picking up the tail of a frame already in flight at reset release
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_HI: if (w_cs_s)    w_state_nxt = IDLE;
         IDLE:    if (w_cs_fall) w_state_nxt = SHIFT;
         SHIFT:   if (w_cs_rise) w_state_nxt = LATCH;
         LATCH:                  w_state_nxt = IDLE;
         default:                w_state_nxt = WAIT_HI;
      endcase
   end

   assign w_latch  = (r_state == LATCH);
   assign w_accept = w_latch && (r_count == 5'(FRAME_BITS));

   // The top nibble of a frame is don't-care, so only the low 12 bits are kept
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sr         <= '0;
         r_count      <= '0;
         rows         <= '0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         shutdown_n   <= 1'b0;
         display_test <= 1'b0;
         frame_valid  <= 1'b0;
         frame_addr   <= '0;
         frame_data   <= '0;
         frame_err    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (r_state == IDLE && w_cs_fall) begin
            r_sr    <= '0;
            r_count <= '0;
         end else if (r_state == SHIFT && !w_cs_rise && w_clk_rise) begin
            r_sr <= {r_sr[10:0], w_din_s};
            if (r_count != 5'd31) begin
               r_count <= r_count + 5'd1;
            end
         end
         if (w_latch && !w_accept) begin
            frame_err <= 1'b1;
         end
         if (w_accept) begin
            frame_valid <= 1'b1;
            frame_addr  <= r_sr[11:8];
            frame_data  <= r_sr[7:0];
            for (int r = 0; r < 8; r++) begin
               if (r_sr[11:8] == 4'(r + 1)) begin
                  rows[8*r +: 8] <= r_sr[7:0];
               end
            end
            case (r_sr[11:8])
               4'h9:    decode_mode  <= r_sr[7:0];
               4'hA:    intensity    <= r_sr[3:0];
               4'hB:    scan_limit   <= r_sr[2:0];
               4'hC:    shutdown_n   <= r_sr[0];
               4'hF:    display_test <= r_sr[0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_led_rx.sv
`timescale 1ns/1ps
// Self-checking bench for matrix_led_rx: directed scenarios plus randomized frames against a register-file model.
module tb_matrix_led_rx;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        matrix_CLK = 1'b0;
   logic        matrix_DIN = 1'b0;
   logic        matrix_CS = 1'b1;
   logic [63:0] rows;
   logic [7:0]  decode_mode;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic        shutdown_n;
   logic        display_test;
   logic        frame_valid;
   logic [3:0]  frame_addr;
   logic [7:0]  frame_data;
   logic        frame_err;

   matrix_led_rx #(.SYNC_STAGES(SYNC), .FRAME_BITS(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .matrix_CLK(matrix_CLK), .matrix_DIN(matrix_DIN), .matrix_CS(matrix_CS),
      .rows(rows), .decode_mode(decode_mode), .intensity(intensity),
      .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test),
      .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_valid = 0;
   int n_err = 0;
   int cyc = 0;
   int valid_cyc = -1;
   int rise_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         n_valid++;
         valid_cyc = cyc;
      end
      if (frame_err === 1'b1) n_err++;
   end

   // Reference register file
   logic [63:0] m_rows;
   logic [7:0]  m_dec;
   logic [3:0]  m_int;
   logic [2:0]  m_scan;
   logic        m_sd;
   logic        m_dt;

   wire [80:0] dut_vec = {rows, decode_mode, intensity, scan_limit, shutdown_n, display_test};

   function automatic logic [80:0] m_vec();
      return {m_rows, m_dec, m_int, m_scan, m_sd, m_dt};
   endfunction

   task automatic model_reset();
      m_rows = '0; m_dec = '0; m_int = '0; m_scan = '0; m_sd = 1'b0; m_dt = 1'b0;
   endtask

   task automatic model_apply(input logic [3:0] addr, input logic [7:0] data);
      int a;
      a = int'(addr);
      if (a >= 1 && a <= 8) m_rows[8*(a-1) +: 8] = data;
      else if (a == 9)  m_dec  = data;
      else if (a == 10) m_int  = data[3:0];
      else if (a == 11) m_scan = data[2:0];
      else if (a == 12) m_sd   = data[0];
      else if (a == 15) m_dt   = data[0];
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         matrix_DIN = v[i];
         wait_cyc(4);
         matrix_CLK = 1'b1;
         wait_cyc(4);
         matrix_CLK = 1'b0;
      end
   endtask

   task automatic send(input logic [31:0] v, input int n);
      matrix_CS = 1'b0;
      wait_cyc(4);
      drive_bits(v, n);
      wait_cyc(4);
      matrix_CS = 1'b1;
      rise_cyc = cyc;
      wait_cyc(10);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      matrix_CS = 1'b1;
      wait_cyc(4);
      model_reset();
      n_chk++;
      if (dut_vec !== 81'd0) $display("FAIL reset_regs got=%h want=0", dut_vec);
      else n_pass++;
      n_chk++;
      if ({frame_valid, frame_err, frame_addr, frame_data} !== 14'd0)
         $display("FAIL reset_frame got=%h want=0", {frame_valid, frame_err, frame_addr, frame_data});
      else n_pass++;
      reset_n = 1'b1;
      wait_cyc(6);
   endtask

   task automatic test_basic();
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send(32'h0C01, 16);
      model_apply(4'hC, 8'h01);
      n_chk++;
      if (n_valid - v0 != 1) $display("FAIL basic_valid_count got=%0d want=1", n_valid - v0);
      else n_pass++;
      n_chk++;
      if (n_err != e0) $display("FAIL basic_err_count got=%0d want=0", n_err - e0);
      else n_pass++;
      n_chk++;
      if (valid_cyc - rise_cyc != SYNC + 2) $display("FAIL basic_latency got=%0d want=%0d", valid_cyc - rise_cyc, SYNC + 2);
      else n_pass++;
      n_chk++;
      if ({frame_addr, frame_data} !== 12'hC01) $display("FAIL basic_frame got=%h want=c01", {frame_addr, frame_data});
      else n_pass++;
      n_chk++;
      if (shutdown_n !== 1'b1 || dut_vec !== m_vec()) $display("FAIL basic_regs got=%h want=%h", dut_vec, m_vec());
      else n_pass++;
   endtask

   task automatic test_rows();
      logic [7:0] pat [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      for (int i = 0; i < 8; i++) begin
         send({16'h0, 4'h0, 4'(i + 1), pat[i]}, 16);
         model_apply(4'(i + 1), pat[i]);
      end
      n_chk++;
      if (rows !== m_rows) $display("FAIL rows_image got=%h want=%h", rows, m_rows);
      else n_pass++;
      n_chk++;
      if (n_valid - v0 != 8 || n_err != e0)
         $display("FAIL rows_pulses got valid=%0d err=%0d want valid=8 err=0", n_valid - v0, n_err - e0);
      else n_pass++;
   endtask

   task automatic test_bad_len();
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send(32'h0155, 15);
      n_chk++;
      if (n_err - e0 != 1 || n_valid != v0)
         $display("FAIL short_frame got err=%0d valid=%0d want err=1 valid=0", n_err - e0, n_valid - v0);
      else n_pass++;
      send(32'h1_0155, 17);
      n_chk++;
      if (n_err - e0 != 2 || n_valid != v0)
         $display("FAIL long_frame got err=%0d valid=%0d want err=2 valid=0", n_err - e0, n_valid - v0);
      else n_pass++;
      n_chk++;
      if (dut_vec !== m_vec()) $display("FAIL bad_len_regs got=%h want=%h", dut_vec, m_vec());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int v0, e0;
      logic [31:0] v;
      v = 32'h0133;
      matrix_CS = 1'b0;
      wait_cyc(4);
      drive_bits(v >> 7, 9);
      reset_n = 1'b0;
      wait_cyc(3);
      reset_n = 1'b1;
      model_reset();
      v0 = n_valid; e0 = n_err;
      wait_cyc(2);
      drive_bits(v & 32'h7F, 7);
      wait_cyc(4);
      matrix_CS = 1'b1;
      wait_cyc(10);
      n_chk++;
      if (n_valid != v0 || n_err != e0)
         $display("FAIL reset_mid_pulses got valid=%0d err=%0d want 0 0", n_valid - v0, n_err - e0);
      else n_pass++;
      n_chk++;
      if (dut_vec !== m_vec()) $display("FAIL reset_mid_regs got=%h want=%h", dut_vec, m_vec());
      else n_pass++;
      send(32'h0A07, 16);
      model_apply(4'hA, 8'h07);
      n_chk++;
      if (intensity !== 4'd7 || n_valid - v0 != 1)
         $display("FAIL reset_mid_recover got int=%0d valid=%0d want int=7 valid=1", intensity, n_valid - v0);
      else n_pass++;
   endtask

   task automatic test_noop();
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send(32'h0DFF, 16);
      send(32'h00FF, 16);
      send(32'h0EFF, 16);
      n_chk++;
      if (n_valid - v0 != 3 || n_err != e0)
         $display("FAIL noop_pulses got valid=%0d err=%0d want valid=3 err=0", n_valid - v0, n_err - e0);
      else n_pass++;
      n_chk++;
      if (dut_vec !== m_vec()) $display("FAIL noop_regs got=%h want=%h", dut_vec, m_vec());
      else n_pass++;
      n_chk++;
      if ({frame_addr, frame_data} !== 12'hEFF) $display("FAIL noop_frame got=%h want=eff", {frame_addr, frame_data});
      else n_pass++;
   endtask

   task automatic test_clk_cs_high();
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      for (int i = 0; i < 20; i++) begin
         matrix_DIN = 1'($urandom_range(0, 1));
         wait_cyc(4);
         matrix_CLK = 1'b1;
         wait_cyc(4);
         matrix_CLK = 1'b0;
      end
      wait_cyc(8);
      n_chk++;
      if (n_valid != v0 || n_err != e0)
         $display("FAIL idle_clk_pulses got valid=%0d err=%0d want 0 0", n_valid - v0, n_err - e0);
      else n_pass++;
      send(32'h0B05, 16);
      model_apply(4'hB, 8'h05);
      n_chk++;
      if (scan_limit !== 3'd5 || dut_vec !== m_vec() || n_valid - v0 != 1)
         $display("FAIL idle_clk_then_frame got=%h want=%h valid=%0d", dut_vec, m_vec(), n_valid - v0);
      else n_pass++;
   endtask

   task automatic test_random();
      int v0, e0, len, sel;
      logic [3:0] addr;
      logic [7:0] data;
      logic [31:0] v;
      for (int k = 0; k < 30; k++) begin
         v0 = n_valid; e0 = n_err;
         addr = 4'($urandom_range(0, 15));
         data = 8'($urandom_range(0, 255));
         sel = $urandom_range(0, 9);
         len = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
         v = {15'($urandom), 1'($urandom), 4'($urandom), addr, data};
         send(v, len);
         if (len == 16) model_apply(addr, data);
         n_chk++;
         if ((len == 16 && (n_valid - v0 != 1 || n_err != e0)) ||
             (len != 16 && (n_err - e0 != 1 || n_valid != v0)))
            $display("FAIL rand_pulses k=%0d len=%0d got valid=%0d err=%0d", k, len, n_valid - v0, n_err - e0);
         else n_pass++;
         n_chk++;
         if (dut_vec !== m_vec()) $display("FAIL rand_regs k=%0d got=%h want=%h", k, dut_vec, m_vec());
         else n_pass++;
         if (len == 16) begin
            n_chk++;
            if ({frame_addr, frame_data} !== {addr, data})
               $display("FAIL rand_frame k=%0d got=%h want=%h", k, {frame_addr, frame_data}, {addr, data});
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rows();
      test_bad_len();
      test_reset_mid();
      test_noop();
      test_clk_cs_high();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
